// File: rtl/fetch_queue_stage.sv
// Fetch stage: issues FETCH_W I-cache lookups per cycle and buffers the hitting prefix in a circular queue for decode.
// Optional macro FQ_PERF_CNT_EN adds saturating fetched/full-cycle/squash counters.
module fetch_queue_stage #(
  parameter int FETCH_W  = 2,
  parameter int DISP_W   = 2,
  parameter int FQ_DEPTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [31:0]                      redirect_pc,
  output logic [31:0]                      bp_pc,
  input  logic [FETCH_W-1:0]               bp_taken,
  input  logic [FETCH_W*32-1:0]            bp_target,
  output logic [FETCH_W-1:0]               ic_req,
  output logic [FETCH_W*32-1:0]            ic_addr,
  input  logic [FETCH_W-1:0]               ic_hit,
  input  logic [FETCH_W*64-1:0]            ic_data,
  output logic [DISP_W-1:0]                id_valid,
  output logic [DISP_W*32-1:0]             id_pc,
  output logic [DISP_W*32-1:0]             id_inst,
  output logic [DISP_W-1:0]                id_pred_taken,
  output logic [DISP_W*32-1:0]             id_pred_target,
  input  logic [$clog2(DISP_W+1)-1:0]      id_take,
`ifdef FQ_PERF_CNT_EN
  output logic [31:0]                      perf_fetched,
  output logic [31:0]                      perf_full_cycles,
  output logic [31:0]                      perf_squashes,
`endif
  output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count
);

  localparam int PTR_W  = $clog2(FQ_DEPTH);
  localparam int CNT_W  = $clog2(FQ_DEPTH+1);
  localparam int TAKE_W = $clog2(DISP_W+1);

  logic [31:0]      pc_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic [31:0] fq_pc_r     [FQ_DEPTH];
  logic [31:0] fq_inst_r   [FQ_DEPTH];
  logic        fq_taken_r  [FQ_DEPTH];
  logic [31:0] fq_target_r [FQ_DEPTH];

  logic [CNT_W-1:0] free_s;
  logic [CNT_W-1:0] k_s;
  logic             run_s;
  logic [31:0]      pc_next_s;
  logic [31:0]      slot_addr_s [FETCH_W];
  logic [31:0]      slot_inst_s [FETCH_W];
  logic [PTR_W-1:0] wr_idx_s    [FETCH_W];
  logic [PTR_W-1:0] rd_idx_s    [DISP_W];

  // Lookup slots, request gating, hitting-prefix length and next fetch PC
  always_comb begin
    free_s    = CNT_W'(FQ_DEPTH) - count_r;
    k_s       = '0;
    run_s     = 1'b1;
    pc_next_s = pc_r;
    ic_req    = '0;
    ic_addr   = '0;
    slot_addr_s[0] = pc_r;
    for (int i = 1; i < FETCH_W; i++) begin
      slot_addr_s[i] = bp_target[(i-1)*32 +: 32];
    end
    for (int i = 0; i < FETCH_W; i++) begin
      ic_req[i]           = !reset && !squash && (CNT_W'(i) < free_s);
      ic_addr[i*32 +: 32] = slot_addr_s[i];
      slot_inst_s[i]      = slot_addr_s[i][2] ? ic_data[i*64+32 +: 32] : ic_data[i*64 +: 32];
      wr_idx_s[i]         = tail_r + PTR_W'(i);
      // the first non-hitting slot ends the push group
      if (run_s && ic_req[i] && ic_hit[i]) begin
        k_s = k_s + CNT_W'(1);
      end else begin
        run_s = 1'b0;
      end
    end
    for (int i = 0; i < FETCH_W; i++) begin
      pc_next_s = (CNT_W'(i+1) == k_s) ? bp_target[i*32 +: 32] : pc_next_s;
    end
  end

  assign bp_pc    = pc_r;
  assign fq_count = count_r;

  // Decode window: entries head..head+DISP_W-1 straight from registered state
  always_comb begin
    id_valid       = '0;
    id_pc          = '0;
    id_inst        = '0;
    id_pred_taken  = '0;
    id_pred_target = '0;
    for (int i = 0; i < DISP_W; i++) begin
      rd_idx_s[i] = head_r + PTR_W'(i);
      if (CNT_W'(i) < count_r) begin
        id_valid[i]              = 1'b1;
        id_pc[i*32 +: 32]        = fq_pc_r[rd_idx_s[i]];
        id_inst[i*32 +: 32]      = fq_inst_r[rd_idx_s[i]];
        id_pred_taken[i]         = fq_taken_r[rd_idx_s[i]];
        id_pred_target[i*32 +: 32] = fq_target_r[rd_idx_s[i]];
      end else begin
        id_inst[i*32 +: 32]      = 32'h0000_0013;
      end
    end
  end

  // Pointer, occupancy and fetch PC registers; squash overrides push and pop
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r    <= 32'h0000_0000;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (squash) begin
      pc_r    <= redirect_pc;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      pc_r    <= pc_next_s;
      head_r  <= head_r + PTR_W'(id_take);
      tail_r  <= tail_r + PTR_W'(k_s);
      count_r <= count_r + k_s - CNT_W'(id_take);
    end
  end

  // Queue storage write of the hitting prefix
  always_ff @(posedge clock) begin
    if (!reset && !squash) begin
      for (int j = 0; j < FETCH_W; j++) begin
        if (CNT_W'(j) < k_s) begin
          fq_pc_r[wr_idx_s[j]]     <= slot_addr_s[j];
          fq_inst_r[wr_idx_s[j]]   <= slot_inst_s[j];
          fq_taken_r[wr_idx_s[j]]  <= bp_taken[j];
          fq_target_r[wr_idx_s[j]] <= bp_target[j*32 +: 32];
        end
      end
    end
  end

`ifdef FQ_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_full_cycles_r;
  logic [31:0] perf_squashes_r;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  // Saturating event counters; only reset clears them
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_r     <= 32'h0000_0000;
      perf_full_cycles_r <= 32'h0000_0000;
      perf_squashes_r    <= 32'h0000_0000;
    end else begin
      perf_fetched_r     <= sat_add(perf_fetched_r, 32'(k_s));
      perf_full_cycles_r <= sat_add(perf_full_cycles_r,
                                    {31'h0, (!squash && (count_r == CNT_W'(FQ_DEPTH)))});
      perf_squashes_r    <= sat_add(perf_squashes_r, {31'h0, squash});
    end
  end

  assign perf_fetched     = perf_fetched_r;
  assign perf_full_cycles = perf_full_cycles_r;
  assign perf_squashes    = perf_squashes_r;
`endif

  fetch_queue_stage_chk #(.CNT_W(CNT_W), .TAKE_W(TAKE_W)) u_chk (
    .clock   (clock),
    .reset   (reset),
    .squash  (squash),
    .count   (count_r),
    .id_take (id_take)
  );

endmodule

// Simulation-only protocol checks on the decode handshake.
module fetch_queue_stage_chk #(
  parameter int CNT_W  = 4,
  parameter int TAKE_W = 2
) (
  input logic              clock,
  input logic              reset,
  input logic              squash,
  input logic [CNT_W-1:0]  count,
  input logic [TAKE_W-1:0] id_take
);

  localparam int W = (CNT_W > TAKE_W) ? CNT_W : TAKE_W;

  a_take_le_count: assert property (@(posedge clock) disable iff (reset || squash)
    W'(id_take) <= W'(count));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: stimulus pushes expected entries, a monitor pops them as decode consumes.
module tb_fetch_queue_stage;

  logic         clock = 1'b0;
  logic         reset, squash;
  logic [31:0]  redirect_pc, bp_pc;
  logic [1:0]   bp_taken, ic_req, ic_hit, id_valid, id_pred_taken, id_take;
  logic [63:0]  bp_target, ic_addr, id_pc, id_inst, id_pred_target;
  logic [127:0] ic_data;
  logic [3:0]   fq_count;
`ifdef FQ_PERF_CNT_EN
  logic [31:0]  perf_fetched, perf_full_cycles, perf_squashes;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;
  int          exp_count;

  fetch_queue_stage dut (
    .clock(clock), .reset(reset), .squash(squash), .redirect_pc(redirect_pc),
    .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_data(ic_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .id_take(id_take),
`ifdef FQ_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_full_cycles(perf_full_cycles),
    .perf_squashes(perf_squashes),
`endif
    .fq_count(fq_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] lo_w(input logic [31:0] a);
    return {16'hA000, a[15:0]};
  endfunction

  function automatic logic [31:0] up_w(input logic [31:0] a);
    return {16'hB000, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every entry decode consumes must match the scoreboard head
  always @(negedge clock) begin
    if (!reset && !squash) begin
      for (int i = 0; i < int'(id_take); i++) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_empty: got slot %0d consumed expected no entry", i);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_valid",  {63'h0, id_valid[i]}, 64'h1);
          chk("pop_pc",     {32'h0, id_pc[i*32 +: 32]}, {32'h0, mon_e.pc});
          chk("pop_inst",   {32'h0, id_inst[i*32 +: 32]}, {32'h0, mon_e.inst});
          chk("pop_taken",  {63'h0, id_pred_taken[i]}, {63'h0, mon_e.taken});
          chk("pop_target", {32'h0, id_pred_target[i*32 +: 32]}, {32'h0, mon_e.target});
        end
      end
    end
  end

  // One fetch cycle: drive, check combinational outputs, update the expected model
  task automatic cyc(input logic [1:0] hit, input logic [1:0] tk, input logic [31:0] tgt0,
                     input int take, input logic sq, input logic [31:0] rpc);
    logic [31:0] a0, a1, t0, t1;
    logic [1:0]  req, vmask;
    int          k;
    a0 = exp_pc;
    t0 = tk[0] ? tgt0 : a0 + 32'd4;
    a1 = t0;
    t1 = a1 + 32'd4;
    ic_hit      = hit;
    bp_taken    = tk;
    bp_target   = {t1, t0};
    ic_data     = {up_w(a1), lo_w(a1), up_w(a0), lo_w(a0)};
    id_take     = 2'(take);
    squash      = sq;
    redirect_pc = rpc;
    req   = sq ? 2'b00 : ((8 - exp_count) >= 2) ? 2'b11 : ((8 - exp_count) == 1) ? 2'b01 : 2'b00;
    vmask = (exp_count >= 2) ? 2'b11 : (exp_count == 1) ? 2'b01 : 2'b00;
    @(negedge clock);
    chk("ic_req",   {62'h0, ic_req}, {62'h0, req});
    chk("ic_addr",  ic_addr, {a1, a0});
    chk("bp_pc",    {32'h0, bp_pc}, {32'h0, a0});
    chk("fq_count", {60'h0, fq_count}, 64'(exp_count));
    chk("id_valid", {62'h0, id_valid}, {62'h0, vmask});
    if (sq) begin
      exp_q.delete();
      exp_count = 0;
      exp_pc    = rpc;
    end else begin
      k = 0;
      if (req[0] && hit[0]) begin
        k = 1;
        if (req[1] && hit[1]) k = 2;
      end
      if (k >= 1) exp_q.push_back('{pc: a0, inst: (a0[2] ? up_w(a0) : lo_w(a0)), taken: tk[0], target: t0});
      if (k >= 2) exp_q.push_back('{pc: a1, inst: (a1[2] ? up_w(a1) : lo_w(a1)), taken: tk[1], target: t1});
      exp_count = exp_count + k - take;
      exp_pc    = (k == 0) ? exp_pc : (k == 1) ? t0 : t1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; squash = 1'b0; id_take = 2'b00; ic_hit = 2'b00;
    @(negedge clock);
    chk("rst_ic_req", {62'h0, ic_req}, 64'h0);
    @(posedge clock);
    #1;
    chk("rst_fq_count", {60'h0, fq_count}, 64'h0);
    chk("rst_id_valid", {62'h0, id_valid}, 64'h0);
    chk("rst_bp_pc",    {32'h0, bp_pc}, 64'h0);
    exp_q.delete();
    exp_pc    = 32'h0;
    exp_count = 0;
    reset     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; redirect_pc = 32'h0; bp_taken = 2'b00;
    bp_target = 64'h0; ic_hit = 2'b00; ic_data = 128'h0; id_take = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    apply_reset();

    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    chk("first_count", {60'h0, fq_count}, 64'h2);
    chk("first_id_pc", id_pc, 64'h0000_0004_0000_0000);
    chk("first_id_inst", id_inst, 64'hB000_0004_A000_0000);
    chk("second_addr0", {32'h0, ic_addr[31:0]}, 64'h8);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    // slot 1 hits but slot 0 misses: nothing pushed, same PC retried
    cyc(2'b10, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    chk("miss_retry_pc", {32'h0, ic_addr[31:0]}, 64'h10);
    chk("miss_count", {60'h0, fq_count}, 64'h4);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    chk("full_count", {60'h0, fq_count}, 64'h8);
    chk("full_pc_hold", {32'h0, bp_pc}, 64'h20);
    cyc(2'b00, 2'b00, 32'h0, 2, 1'b0, 32'h0);
    chk("after_pop_count", {60'h0, fq_count}, 64'h6);
    chk("after_pop_req", {62'h0, ic_req}, 64'h3);
    cyc(2'b11, 2'b00, 32'h0, 2, 1'b0, 32'h0);
    cyc(2'b11, 2'b01, 32'h104, 2, 1'b0, 32'h0);
    cyc(2'b01, 2'b00, 32'h0, 2, 1'b0, 32'h0);
    chk("pre_squash_count", {60'h0, fq_count}, 64'h5);
    cyc(2'b11, 2'b00, 32'h0, 2, 1'b1, 32'h200);
    squash = 1'b0;
    chk("squash_count", {60'h0, fq_count}, 64'h0);
    chk("squash_valid", {62'h0, id_valid}, 64'h0);
    chk("squash_addr0", {32'h0, ic_addr[31:0]}, 64'h200);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    cyc(2'b00, 2'b00, 32'h0, 2, 1'b0, 32'h0);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);

    apply_reset();
    repeat (4)  cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    repeat (10) cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b1, 32'h40);
    squash = 1'b0;
    chk("post_squash_pc", {32'h0, bp_pc}, 64'h40);
`ifdef FQ_PERF_CNT_EN
    chk("perf_full_cycles", {32'h0, perf_full_cycles}, 64'd10);
    chk("perf_squashes",    {32'h0, perf_squashes}, 64'd1);
    chk("perf_fetched",     {32'h0, perf_fetched}, 64'd8);
`endif
    cyc(2'b11, 2'b00, 32'h0, 0, 1'b0, 32'h0);
    cyc(2'b00, 2'b00, 32'h0, 2, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised next-generation fetch stage. Issues up to FETCH_W I-cache lookups per cycle along the predicted path and pushes the hitting prefix into a FQ_DEPTH-entry circular fetch queue. Decode pops up to DISP_W entries per cycle from the queue. This decouples I-cache hit timing from decode stalls. Sits between the icache/branch predictor and the decode/dispatch stage. A squash flushes the queue and redirects the fetch PC.

Parameters:
FETCH_W, 2, lookups/pushes per cycle (1..4)
DISP_W, 2, max entries presented to decode per cycle (1..FETCH_W*2)
FQ_DEPTH, 8, queue entries; power of 2, >= FETCH_W

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
squash  in  1  flush queue, redirect fetch
redirect_pc  in  32  new fetch PC on squash
bp_pc  out  32  current fetch PC to predictor
bp_taken  in  FETCH_W  predicted taken per slot
bp_target  in  FETCH_W*32  predicted next PC per slot
ic_req  out  FETCH_W  lookup valid per slot
ic_addr  out  FETCH_W*32  lookup address per slot
ic_hit  in  FETCH_W  same-cycle hit per slot
ic_data  in  FETCH_W*64  8-byte block per slot
id_valid  out  DISP_W  decode slot valid
id_pc  out  DISP_W*32  slot PC
id_inst  out  DISP_W*32  slot instruction
id_pred_taken  out  DISP_W  slot prediction
id_pred_target  out  DISP_W*32  slot predicted next PC
id_take  in  $clog2(DISP_W+1)  entries consumed this cycle
fq_count  out  $clog2(FQ_DEPTH+1)  occupancy

Behaviour:
- State: pc (32), head, tail (log2 depth), count, FQ_DEPTH entries {pc, inst, taken, target}.
- Reset:
  - pc=0, head=tail=count=0.
  - All id_valid=0, ic_req=0, fq_count=0.
- Slot addressing:
  - ic_addr[0]=pc; ic_addr[i]=bp_target[i-1] for i>0.
  - bp_pc=pc.
- Request gating:
  - free = FQ_DEPTH-count, using registered count only; no same-cycle pop credit.
  - ic_req[i] = !squash && (i < free).
- Push count:
  - k = number of leading slots with ic_req && ic_hit.
  - The first non-hit slot ends the group; later hits are discarded.
- Entry contents:
  - Slot j<k is written at (tail+j) mod FQ_DEPTH.
  - inst = PC[2] ? ic_data[j][63:32] : ic_data[j][31:0].
  - taken/target come from bp_taken[j]/bp_target[j].
- Next PC: k>0 -> bp_target[k-1]; k=0 -> pc unchanged (miss retries the same PC).
- Pop:
  - id slot i shows entry (head+i) mod FQ_DEPTH, combinationally from registered state.
  - id_valid[i] = (i < count); invalid slots drive inst=32'h00000013 (NOP) and pc=0.
  - head advances by id_take; id_take>count is illegal and must be asserted against in simulation.
- Count update: count_next = count + k - id_take; simultaneous push and pop allowed.
- Wrap-around: head/tail wrap modulo FQ_DEPTH.
- Full: count==FQ_DEPTH -> all ic_req=0, pc holds.
- Latency: a hit in cycle t is visible to decode in cycle t+1; there is no icache->decode bypass.
- Squash (priority over everything):
  - Next edge: count=head=tail=0, pc=redirect_pc.
  - No push; id_take is ignored.
  - ic_req=0 in the squash cycle.
- Reset asserted mid-operation behaves identically to the power-on reset above.

Optional Feature:
FQ_PERF_CNT_EN:
- Defined: adds output ports perf_fetched (32, total entries pushed), perf_full_cycles (32, cycles with count==FQ_DEPTH and !squash), and perf_squashes (32).
  - All three are cleared on reset and saturate at all-ones.
  - They are not cleared by squash.
- Undefined: these ports and their counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then all ic_hit=1 with bp_target[i]=addr+4:
  - Cycle 1 shows ic_addr={0,4}.
  - Next cycle fq_count=2, id_pc={0,4}, and ic_addr={8,C}.
- ic_hit=2'b10 at pc=0x10 -> k=0, nothing pushed, pc stays 0x10, ic_addr[0]=0x10 again.
- id_take=0 with all hits:
  - Queue fills 0->2->4->6->8; then ic_req=0 and pc holds.
  - Then id_take=2 -> next cycle count=6 and ic_req=2'b11 again.
- Fill queue and drain past index 7:
  - Entry order is preserved across wrap-around.
  - id_inst picks the upper word for PC=0x...4.
- Squash with redirect_pc=0x200 while count=5, id_take=2:
  - Next cycle fq_count=0, all id_valid=0.
  - ic_addr[0]=0x200.
- FQ_PERF_CNT_EN: 10 full cycles and 1 squash -> perf_full_cycles=10, perf_squashes=1.
